// File: rtl/vote_button_driver.sv
// Replays queued vote/readout requests as timed one-hot presses on mode/button1..4.
// Requests enter a small FIFO over valid/ready; each press is a hold then a release gap.
//
// state | meaning
// IDLE  | nothing in flight; pops the FIFO head as soon as one is queued
// PRESS | one button (and mode for readouts) held high for HOLD_CYCLES
// GAP   | everything low for GAP_CYCLES; done pulses in the first cycle
module vote_button_driver #(
  parameter int HOLD_CYCLES = 11,
  parameter int GAP_CYCLES  = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [1:0]                  req_cand,
  input  logic                        req_readout,
  output logic                        mode,
  output logic                        button1,
  output logic                        button2,
  output logic                        button3,
  output logic                        button4,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(FIFO_DEPTH):0] pending
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0]    HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]    GAP_LOAD  = 8'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t        state, state_nxt;
  logic [2:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  logic [7:0]    hold_cnt, gap_cnt;
  logic [3:0]    btn;
  logic          push, pop;
  logic [2:0]    head;

  assign push = req_valid && req_ready;
  assign head = fifo_mem[rd_ptr];
  assign {button4, button3, button2, button1} = btn;

  // pending is the occupancy register; a push landing this edge is not poppable until next
  always_comb begin
    pop       = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          pop       = 1'b1;
          state_nxt = PRESS;
        end
      end
      PRESS: begin
        if (hold_cnt == '0) state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt == '0) begin
          if (pending != '0) begin
            pop       = 1'b1;
            state_nxt = PRESS;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    count_nxt = pending + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_readout, req_cand};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pending   <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      btn       <= '0;
      mode      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= count_nxt;
      req_ready <= (count_nxt != FULL);
      busy      <= (state_nxt != IDLE) || (count_nxt != '0);
      done      <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop) begin
        hold_cnt <= HOLD_LOAD;
        btn      <= 4'b0001 << head[1:0];
        mode     <= head[2];
      end else if (state == PRESS) begin
        if (hold_cnt == '0) begin
          btn     <= '0;
          mode    <= 1'b0;
          done    <= 1'b1;
          gap_cnt <= GAP_LOAD;
        end else begin
          hold_cnt <= hold_cnt - 8'd1;
        end
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
    end
  end

`ifndef SYNTHESIS
  logic [8:0] run_len;
  logic [3:0] btn_q;
  logic       mode_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_len <= '0;
      btn_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      run_len <= (btn != '0) ? run_len + 9'd1 : '0;
      btn_q   <= btn;
      mode_q  <= mode;
      assert ($countones(btn) <= 1) else $error("more than one button high");
      assert (mode == mode_q || btn == '0 || btn_q == '0)
        else $error("mode changed while a button was held");
      assert (run_len <= 9'(HOLD_CYCLES)) else $error("button held too long");
    end
  end
`endif

endmodule

// File: tb/tb_vote_button_driver.sv
// Bench for vote_button_driver: lane 0 uses default parameters, lane 1 uses HOLD=3/GAP=1/DEPTH=2.
// Accepted requests feed per-lane queues; a per-lane monitor predicts every output each cycle.
module tb_vote_button_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid_v [2];
  logic [1:0] req_cand_v  [2];
  logic       req_ro_v    [2];
  logic [1:0] req_ready_v;
  logic [1:0] busy_v;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int g, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s lane%0d @%0t: got %0d, expected %0d", name, g, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int H  = (g == 0) ? 11 : 3;
    localparam int G  = (g == 0) ? 4 : 1;
    localparam int D  = (g == 0) ? 4 : 2;
    localparam int PW = $clog2(D) + 1;

    logic          mode, b1, b2, b3, b4, done_p;
    logic [PW-1:0] pending;

    vote_button_driver #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .FIFO_DEPTH(D)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid_v[g]),
      .req_ready  (req_ready_v[g]),
      .req_cand   (req_cand_v[g]),
      .req_readout(req_ro_v[g]),
      .mode       (mode),
      .button1    (b1),
      .button2    (b2),
      .button3    (b3),
      .button4    (b4),
      .busy       (busy_v[g]),
      .done       (done_p),
      .pending    (pending)
    );

    // Reference: a request accepted at edge a is popped at edge max(a+1, prev_start+H+G)
    // and its button is high for samples start..start+H-1; sample n follows edge n.
    int q_cand[$];
    int q_ro[$];
    int q_acc[$];
    int  ecyc = 0, acc_cnt = 0, pops = 0;
    int  last_start = 0, cur_cand = 0, cur_ro = 0;
    int  hs, btns, pend, prev_btns = 0;
    bit  have_last = 0, in_press;
    bit  nx_rst = 1, nx_acc = 0;
    int  nx_cand = 0, nx_ro = 0;

    always @(negedge clk) begin
      ecyc++;
      if (nx_rst) begin
        q_cand.delete(); q_ro.delete(); q_acc.delete();
        acc_cnt = 0; pops = 0; have_last = 0;
      end else if (nx_acc) begin
        q_cand.push_back(nx_cand); q_ro.push_back(nx_ro); q_acc.push_back(ecyc);
        acc_cnt++;
      end

      btns = int'({b4, b3, b2, b1});
      check("onehot", g, ($countones({b4, b3, b2, b1}) <= 1) ? 1 : 0, 1);

      hs = 0;
      if (q_acc.size() != 0) begin
        hs = q_acc[0] + 1;
        if (have_last && last_start + H + G > hs) hs = last_start + H + G;
      end

      if (btns != 0 && prev_btns == 0) begin
        if (q_cand.size() == 0) begin
          check("unexpected_press", g, btns, 0);
        end else begin
          check("press_start", g, ecyc, hs);
          check("press_button", g, btns, 1 << q_cand[0]);
          check("press_mode", g, int'(mode), q_ro[0]);
          last_start = ecyc; have_last = 1;
          cur_cand = q_cand[0]; cur_ro = q_ro[0];
          void'(q_cand.pop_front()); void'(q_ro.pop_front()); void'(q_acc.pop_front());
          pops++;
        end
      end else if (q_acc.size() != 0 && hs < ecyc) begin
        check("press_late", g, ecyc, hs);
        void'(q_cand.pop_front()); void'(q_ro.pop_front()); void'(q_acc.pop_front());
        pops++;
      end

      in_press = have_last && ecyc >= last_start && ecyc < last_start + H;
      check("buttons", g, btns, in_press ? (1 << cur_cand) : 0);
      check("mode", g, int'(mode), in_press ? cur_ro : 0);
      check("done", g, int'(done_p), (have_last && ecyc == last_start + H) ? 1 : 0);
      pend = acc_cnt - pops;
      check("pending", g, int'(pending), pend);
      check("busy", g, int'(busy_v[g]),
            (pend > 0 || (have_last && ecyc >= last_start && ecyc < last_start + H + G)) ? 1 : 0);
      check("req_ready", g, int'(req_ready_v[g]), (pend < D) ? 1 : 0);
      prev_btns = btns;

      // inputs are stable from here to the next edge
      nx_rst  = !rst;
      nx_acc  = rst && req_valid_v[g] && req_ready_v[g];
      nx_cand = int'(req_cand_v[g]);
      nx_ro   = int'(req_ro_v[g]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int g, input int cand, input int ro);
    int t = 0;
    req_cand_v[g]  = 2'(cand);
    req_ro_v[g]    = ro[0];
    req_valid_v[g] = 1'b1;
    while (!req_ready_v[g] && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) check("accept_timeout", g, t, 0);
    step();
    req_valid_v[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int t = 0;
    repeat (2) step();
    while (busy_v[g] && t < 400) begin
      step();
      t++;
    end
    if (t >= 400) check("idle_timeout", g, t, 0);
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      req_valid_v[g] = 1'b0;
      req_cand_v[g]  = 2'd0;
      req_ro_v[g]    = 1'b0;
    end
    repeat (2) step();
    rst = 1'b1;
    step();

    send(0, 0, 0);
    wait_idle(0);

    send(0, 1, 0); send(0, 2, 0); send(0, 1, 0);
    wait_idle(0);

    for (int i = 0; i < 6; i++) send(0, i % 4, 0);
    wait_idle(0);

    send(0, 2, 1);
    wait_idle(0);

    // abort in the middle of a hold with two requests still queued
    send(0, 3, 0); send(0, 1, 1); send(0, 2, 0);
    repeat (2) step();
    do_reset();
    repeat (30) step();

    for (int i = 0; i < 5; i++) send(1, (i * 3) % 4, i % 2);
    wait_idle(1);

    for (int i = 0; i < 60; i++) begin
      int g;
      g = int'($urandom_range(1, 0));
      send(g, int'($urandom_range(3, 0)), int'($urandom_range(1, 0)));
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(20, 0)) step();
      if ($urandom_range(24, 0) == 0) do_reset();
    end
    wait_idle(0);
    wait_idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
